bcd_counter_2digit: RTL and testbench
=====================================

Name: bcd_counter_2digit

Overview:
- Two-digit decimal up/down counter that produces the BCD nibbles feeding the team's two-digit 7-segment decoder (tens to HEX1 decoder input, units to HEX0 decoder input).
- Pushbuttons are synchronised, debounced and edge-detected inside the block.
- Start/stop, direction and parallel load come from board keys and switches.
- Outputs are always valid BCD (0-9 per digit), so the downstream decoder never sees 10-15.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per count step (1 Hz at 50 MHz); legal range 2 or more.
- DEB_CYCLES, 500000, consecutive stable synchronised samples required before a key change is accepted (10 ms); legal range 1 or more.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- KEY_RUN_N  in  1  raw pushbutton, active-low; a debounced press toggles RUN/STOP.
- KEY_LOAD_N  in  1  raw pushbutton, active-low; a debounced press loads SW.
- SW  in  8  load value: SW[7:4] tens, SW[3:0] units.
- UP  in  1  count direction, level: 1 = up, 0 = down; sampled on each tick.
- BCD1  out  4  tens digit.
- BCD0  out  4  units digit.
- RUNNING  out  1  1 while the FSM is in RUN.
- WRAP  out  1  one-cycle pulse on a 99->00 or 00->99 wrap.
- LOAD_ERR  out  1  sticky flag: the last load attempt was rejected.

Behaviour:
- Reset (RESETN=0, asynchronous, held until release):
  - BCD1=0, BCD0=0, RUNNING=0, WRAP=0, LOAD_ERR=0.
  - FSM in STOP, prescaler=0.
  - Debouncers take the released state (1); synchroniser flops are set to 1.
- Key path, per key:
  - 2-flop synchroniser, then a stability counter.
  - The accepted level changes only after DEB_CYCLES consecutive samples differ from the current accepted level. Any sample equal to the accepted level clears the counter.
  - A press event is a one-cycle pulse when the accepted level goes 1->0. Releases generate nothing.
  - Latency from a clean raw press to the press pulse: 2 sync cycles + DEB_CYCLES + 1 cycle.
- FSM states: STOP and RUN.
  - STOP: a run press goes to RUN; the prescaler is cleared on entry.
  - RUN: a run press goes to STOP; the prescaler is frozen and cleared.
  - RUNNING = (state==RUN), registered.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. The tick is asserted in the cycle the count equals TICK_DIV-1; the count then returns to 0.
  - The first step after entering RUN occurs TICK_DIV cycles after the entry edge.
- Count step, on a tick in RUN:
  - UP=1: units+1. Units 9 becomes 0 with carry into tens. 99 becomes 00 and WRAP=1.
  - UP=0: units-1. Units 0 becomes 9 with borrow from tens. 00 becomes 99 and WRAP=1.
  - WRAP is registered and high for exactly the cycle after the wrapping edge.
- Load:
  - A load press in STOP checks both SW nibbles.
    - Both 9 or less: BCD1=SW[7:4], BCD0=SW[3:0], LOAD_ERR=0.
    - Otherwise: count unchanged, LOAD_ERR=1.
  - A load press in RUN is ignored; count and LOAD_ERR are unchanged.
  - LOAD_ERR clears only on reset or on the next valid load.
- Simultaneous events in the same cycle:
  - Run press and load press while in STOP: the load executes and the FSM goes to RUN. The first step follows TICK_DIV cycles later.
  - Run press and tick while in RUN: the tick step executes, then the FSM goes to STOP.
- Mid-operation reset: everything returns to reset values immediately. No tick or load pulse may survive reset deassertion.
- Invariant: BCD1 and BCD0 are each 9 or less at all times.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Common settings: TICK_DIV=4, DEB_CYCLES=3, 50 MHz clock.
- Reset: assert RESETN=0 mid-count at 37 -> BCD1=0, BCD0=0, RUNNING=0, WRAP=0 with no clock edge. Release -> the block stays at 00 in STOP.
- Debounce: KEY_RUN_N low for 2 cycles, then high (glitch) -> RUNNING stays 0. Hold low for 10 cycles -> RUNNING=1 exactly 2+3+1 cycles after the falling edge, plus the registered output stage. Toggle once only despite the long hold.
- Up count and wrap:
  - Load SW=8'h98 in STOP, run, UP=1 -> steps 98, 99, 00, 01 at 4-cycle spacing.
  - WRAP high for one cycle, coincident with 00 appearing.
- Down count and borrow:
  - Load 8'h10, UP=0 -> 10, 09, 08.
  - Load 8'h00, UP=0 -> 99 with a WRAP pulse.
- Load validation:
  - SW=8'h3A -> count unchanged, LOAD_ERR=1.
  - Then SW=8'h42 -> BCD1=4, BCD0=2, LOAD_ERR=0.
  - Load press while RUNNING=1 -> no change.
- Simultaneous events:
  - Run and load presses on the same cycle in STOP with SW=8'h55 -> 55 loaded and RUNNING=1; first step to 56 four cycles later.
  - Run press on a tick cycle -> the step is applied, then RUNNING=0.

Source files
------------

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with debounced run/load keys, feeding a 7-segment decoder pair.
// All outputs come straight from flops; digits never leave the 0-9 range.
module bcd_counter_2digit #(
   parameter int unsigned TICK_DIV   = 50000000,
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       RESETN,
   input  logic       KEY_RUN_N,
   input  logic       KEY_LOAD_N,
   input  logic [7:0] SW,
   input  logic       UP,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0,
   output logic       RUNNING,
   output logic       WRAP,
   output logic       LOAD_ERR
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

   typedef enum logic {StStop, StRun} state_e;

   logic [1:0] key_raw;
   logic [1:0] press;
   logic       run_press;
   logic       load_press;

   assign key_raw    = {KEY_LOAD_N, KEY_RUN_N};
   assign run_press  = press[0];
   assign load_press = press[1];

   // Per key: 2-flop synchroniser, stability counter, accepted level, falling-edge pulse.
   for (genvar k = 0; k < 2; k++) begin : g_key
      logic          sync1_q;
      logic          sync2_q;
      logic          acc_q;
      logic          acc_dly_q;
      logic [DW-1:0] cnt_q;

      always_ff @(posedge CLOCK_50 or negedge RESETN) begin
         if (!RESETN) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            acc_q     <= 1'b1;
            acc_dly_q <= 1'b1;
            cnt_q     <= '0;
         end else begin
            sync1_q   <= key_raw[k];
            sync2_q   <= sync1_q;
            acc_dly_q <= acc_q;
            if (sync2_q == acc_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
               cnt_q <= '0;
               acc_q <= sync2_q;
            end else begin
               cnt_q <= cnt_q + DW'(1);
            end
         end
      end

      assign press[k] = acc_dly_q & ~acc_q;
   end

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    bcd1_q, bcd1_d;
   logic [3:0]    bcd0_q, bcd0_d;
   logic          wrap_q, wrap_d;
   logic          err_q, err_d;
   logic          running_q;
   logic          tick;

   always_comb begin
      state_d = state_q;
      presc_d = '0;
      bcd1_d  = bcd1_q;
      bcd0_d  = bcd0_q;
      wrap_d  = 1'b0;
      err_d   = err_q;
      tick    = 1'b0;
      unique case (state_q)
         StStop: begin
            if (load_press) begin
               if ((SW[7:4] <= 4'd9) && (SW[3:0] <= 4'd9)) begin
                  bcd1_d = SW[7:4];
                  bcd0_d = SW[3:0];
                  err_d  = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (run_press) state_d = StRun;
         end
         StRun: begin
            tick    = (presc_q == PRESC_LAST);
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               if (UP) begin
                  if (bcd0_q == 4'd9) begin
                     bcd0_d = 4'd0;
                     if (bcd1_q == 4'd9) begin
                        bcd1_d = 4'd0;
                        wrap_d = 1'b1;
                     end else begin
                        bcd1_d = bcd1_q + 4'd1;
                     end
                  end else begin
                     bcd0_d = bcd0_q + 4'd1;
                  end
               end else begin
                  if (bcd0_q == 4'd0) begin
                     bcd0_d = 4'd9;
                     if (bcd1_q == 4'd0) begin
                        bcd1_d = 4'd9;
                        wrap_d = 1'b1;
                     end else begin
                        bcd1_d = bcd1_q - 4'd1;
                     end
                  end else begin
                     bcd0_d = bcd0_q - 4'd1;
                  end
               end
            end
            // A stop press still lets a coincident tick step first.
            if (run_press) begin
               state_d = StStop;
               presc_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= StStop;
         presc_q   <= '0;
         bcd1_q    <= 4'd0;
         bcd0_q    <= 4'd0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         bcd1_q    <= bcd1_d;
         bcd0_q    <= bcd0_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         running_q <= (state_q == StRun);
      end
   end

   assign BCD1     = bcd1_q;
   assign BCD0     = bcd0_q;
   assign RUNNING  = running_q;
   assign WRAP     = wrap_q;
   assign LOAD_ERR = err_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed bench for bcd_counter_2digit with TICK_DIV=4, DEB_CYCLES=3.
module tb_bcd_counter_2digit;

   logic       CLOCK_50 = 1'b0;
   logic       RESETN = 1'b1;
   logic       KEY_RUN_N = 1'b1;
   logic       KEY_LOAD_N = 1'b1;
   logic [7:0] SW = 8'h00;
   logic       UP = 1'b1;
   logic [3:0] BCD1;
   logic [3:0] BCD0;
   logic       RUNNING;
   logic       WRAP;
   logic       LOAD_ERR;

   int total = 0;
   int bad = 0;

   bcd_counter_2digit #(
      .TICK_DIV  (4),
      .DEB_CYCLES(3)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .RESETN    (RESETN),
      .KEY_RUN_N (KEY_RUN_N),
      .KEY_LOAD_N(KEY_LOAD_N),
      .SW        (SW),
      .UP        (UP),
      .BCD1      (BCD1),
      .BCD0      (BCD0),
      .RUNNING   (RUNNING),
      .WRAP      (WRAP),
      .LOAD_ERR  (LOAD_ERR)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_reset();
      #3 RESETN = 1'b0;
      cyc(2);
      RESETN = 1'b1;
      cyc(2);
   endtask

   // k=0 run key, k=1 load key; 8 cycles low, 8 cycles to settle.
   task automatic press(input int k);
      if (k == 0) KEY_RUN_N = 1'b0;
      else KEY_LOAD_N = 1'b0;
      cyc(8);
      KEY_RUN_N  = 1'b1;
      KEY_LOAD_N = 1'b1;
      cyc(8);
   endtask

   initial begin
      #2 RESETN = 1'b0;
      #1;
      chk("rst_bcd", {BCD1, BCD0}, 8'h00);
      chk("rst_flags", {5'd0, RUNNING, WRAP, LOAD_ERR}, 8'h00);
      cyc(2);
      RESETN = 1'b1;
      cyc(2);

      // Debounce: glitch then long hold
      KEY_RUN_N = 1'b0;
      cyc(2);
      KEY_RUN_N = 1'b1;
      cyc(8);
      chk("glitch_run", {7'd0, RUNNING}, 8'h00);
      KEY_RUN_N = 1'b0;
      cyc(6);
      chk("deb_run_early", {7'd0, RUNNING}, 8'h00);
      cyc(1);
      chk("deb_run_on", {7'd0, RUNNING}, 8'h01);
      cyc(3);
      KEY_RUN_N = 1'b1;
      cyc(10);
      chk("deb_single_toggle", {7'd0, RUNNING}, 8'h01);
      do_reset();

      // Up count and wrap
      SW = 8'h98;
      press(1);
      chk("load98", {BCD1, BCD0}, 8'h98);
      UP = 1'b1;
      KEY_RUN_N = 1'b0;
      cyc(8);
      KEY_RUN_N = 1'b1;
      cyc(1);
      chk("up_hold98", {BCD1, BCD0}, 8'h98);
      cyc(1);
      chk("up_99", {BCD1, BCD0}, 8'h99);
      chk("up_99_nowrap", {7'd0, WRAP}, 8'h00);
      cyc(4);
      chk("up_00", {BCD1, BCD0}, 8'h00);
      chk("up_wrap", {7'd0, WRAP}, 8'h01);
      cyc(1);
      chk("up_wrap_off", {7'd0, WRAP}, 8'h00);
      cyc(3);
      chk("up_01", {BCD1, BCD0}, 8'h01);
      cyc(2);
      // Run press lands on the tick that steps 02 -> 03
      KEY_RUN_N = 1'b0;
      cyc(2);
      chk("up_02", {BCD1, BCD0}, 8'h02);
      cyc(4);
      chk("stop_tick_step", {BCD1, BCD0}, 8'h03);
      chk("stop_tick_run", {7'd0, RUNNING}, 8'h01);
      cyc(1);
      chk("stop_tick_stopped", {7'd0, RUNNING}, 8'h00);
      cyc(1);
      KEY_RUN_N = 1'b1;
      cyc(8);
      chk("stop_hold03", {BCD1, BCD0}, 8'h03);
      do_reset();

      // Down count and borrow
      SW = 8'h10;
      press(1);
      UP = 1'b0;
      KEY_RUN_N = 1'b0;
      cyc(8);
      KEY_RUN_N = 1'b1;
      cyc(1);
      chk("dn_10", {BCD1, BCD0}, 8'h10);
      cyc(1);
      chk("dn_09", {BCD1, BCD0}, 8'h09);
      cyc(4);
      chk("dn_08", {BCD1, BCD0}, 8'h08);
      do_reset();
      SW = 8'h00;
      press(1);
      KEY_RUN_N = 1'b0;
      cyc(8);
      KEY_RUN_N = 1'b1;
      cyc(2);
      chk("dn_99", {BCD1, BCD0}, 8'h99);
      chk("dn_wrap", {7'd0, WRAP}, 8'h01);
      cyc(1);
      chk("dn_wrap_off", {7'd0, WRAP}, 8'h00);
      do_reset();

      // Load validation
      UP = 1'b1;
      SW = 8'h3A;
      press(1);
      chk("bad_load_bcd", {BCD1, BCD0}, 8'h00);
      chk("bad_load_err", {7'd0, LOAD_ERR}, 8'h01);
      SW = 8'h42;
      press(1);
      chk("good_load_bcd", {BCD1, BCD0}, 8'h42);
      chk("good_load_err", {7'd0, LOAD_ERR}, 8'h00);
      press(0);
      chk("run_44", {BCD1, BCD0}, 8'h44);
      chk("run_on", {7'd0, RUNNING}, 8'h01);
      SW = 8'h77;
      press(1);
      chk("run_load_ignored", {BCD1, BCD0}, 8'h48);
      SW = 8'hFF;
      press(1);
      chk("run_badload_bcd", {BCD1, BCD0}, 8'h52);
      chk("run_badload_err", {7'd0, LOAD_ERR}, 8'h00);
      do_reset();

      // Simultaneous run + load in STOP
      SW = 8'h55;
      KEY_RUN_N  = 1'b0;
      KEY_LOAD_N = 1'b0;
      cyc(6);
      chk("sim_load55", {BCD1, BCD0}, 8'h55);
      cyc(1);
      chk("sim_running", {7'd0, RUNNING}, 8'h01);
      cyc(1);
      KEY_RUN_N  = 1'b1;
      KEY_LOAD_N = 1'b1;
      cyc(1);
      chk("sim_hold55", {BCD1, BCD0}, 8'h55);
      cyc(1);
      chk("sim_step56", {BCD1, BCD0}, 8'h56);
      do_reset();

      // Mid-count asynchronous reset
      SW = 8'h37;
      press(1);
      KEY_RUN_N = 1'b0;
      cyc(8);
      KEY_RUN_N = 1'b1;
      cyc(1);
      chk("pre_rst_37", {BCD1, BCD0}, 8'h37);
      chk("pre_rst_run", {7'd0, RUNNING}, 8'h01);
      #5 RESETN = 1'b0;
      #1;
      chk("async_rst_bcd", {BCD1, BCD0}, 8'h00);
      chk("async_rst_flags", {5'd0, RUNNING, WRAP, LOAD_ERR}, 8'h00);
      cyc(1);
      RESETN = 1'b1;
      cyc(10);
      chk("post_rst_bcd", {BCD1, BCD0}, 8'h00);
      chk("post_rst_run", {7'd0, RUNNING}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
